mux_scan_ctrl: RTL and testbench

//  Upstream sequencer for the 4:1 mux (mux41). Drives the mux select s,

---
 rtl/mux_scan_ctrl.sv | 138 +++++++++++++
 tb/tb_mux_scan_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4:1 mux: steps the select through channels 0..3,
// waits SETTLE cycles per channel, samples y, and hands the 4-bit word out.
module mux_scan_ctrl #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y,
  input  logic       ready,
  output logic [1:0] s,
  output logic       busy,
  output logic       valid,
  output logic [3:0] data
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned K_W    = 2;
  localparam int unsigned DATA_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE);

  state_t              state_q, state_d;
  logic [K_W-1:0]      k_q, k_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-2:0]   shadow_q, shadow_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic [K_W-1:0]      s_q, s_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      s_q      <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      s_q      <= s_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    s_d      = s_q;

    unique case (state_q)
      ST_IDLE: begin
        s_d     = '0;
        busy_d  = 1'b0;
        valid_d = 1'b0;
        if (start) begin
          state_d = ST_SETTLE;
          k_d     = '0;
          cnt_d   = CNT_RELOAD;
          busy_d  = 1'b1;
        end
      end

      ST_SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // Sample edge for channel k; the last channel goes straight into data.
          case (k_q)
            2'd0:    shadow_d[0] = y;
            2'd1:    shadow_d[1] = y;
            2'd2:    shadow_d[2] = y;
            default: ;
          endcase
          if (k_q != 2'd3) begin
            k_d   = k_q + K_W'(1);
            s_d   = k_q + K_W'(1);
            cnt_d = CNT_RELOAD;
          end else begin
            data_d  = {y, shadow_q};
            valid_d = 1'b1;
            busy_d  = 1'b0;
            s_d     = '0;
            state_d = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        s_d = '0;
        if (ready) begin
          valid_d = 1'b0;
          if (start) begin
            // Back-to-back scan: handshake and restart share one edge.
            state_d = ST_SETTLE;
            k_d     = '0;
            cnt_d   = CNT_RELOAD;
            busy_d  = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        s_d     = '0;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  assign s     = s_q;
  assign busy  = busy_q;
  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: a behavioural 4:1 mux feeds y from in_i[s].
module tb_mux_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       start, ready;
  logic [3:0] in_i;
  logic       y;
  logic [1:0] s;
  logic       busy, valid;
  logic [3:0] data;

  logic       start0, ready0;
  logic [3:0] in0;
  logic       y0;
  logic [1:0] s0;
  logic       busy0, valid0;
  logic [3:0] data0;

  int tests;
  int fails;

  typedef struct {
    logic [3:0] pat;
    logic [3:0] exp;
  } vec_t;
  vec_t vecs[6];

  assign y  = in_i[s];
  assign y0 = in0[s0];

  mux_scan_ctrl #(.SETTLE(2)) dut (
    .clk(clk), .rst(rst), .start(start), .y(y), .ready(ready),
    .s(s), .busy(busy), .valid(valid), .data(data)
  );

  mux_scan_ctrl #(.SETTLE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .y(y0), .ready(ready0),
    .s(s0), .busy(busy0), .valid(valid0), .data(data0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive start (with ready) for one edge, then check the scan has begun.
  task automatic start_scan(input logic [3:0] pat, input logic rdy, input string nm);
    @(negedge clk);
    in_i  = pat;
    start = 1'b1;
    ready = rdy;
    @(negedge clk);
    start = 1'b0;
    ready = 1'b0;
    check({nm, " busy@e0"}, int'(busy), 1);
    check({nm, " valid@e0"}, int'(valid), 0);
    check({nm, " s@e0"}, int'(s), 0);
  endtask

  // Walk edges 1..12; in_i = b during edges lo..hi, else a.
  task automatic walk(input logic [3:0] a, input logic [3:0] b, input int lo, input int hi,
                      input logic [3:0] exp, input bit chk_s, input string nm);
    for (int e = 1; e <= 12; e++) begin
      in_i = (e >= lo && e <= hi) ? b : a;
      @(negedge clk);
      if (chk_s) check($sformatf("%s s@e%0d", nm, e), int'(s), (e < 12) ? e / 3 : 0);
      if (e == 11) begin
        check({nm, " valid@e11"}, int'(valid), 0);
        check({nm, " busy@e11"}, int'(busy), 1);
      end
    end
    check({nm, " valid@e12"}, int'(valid), 1);
    check({nm, " busy@e12"}, int'(busy), 0);
    check({nm, " data"}, int'(data), int'(exp));
  endtask

  task automatic handshake(input logic [3:0] exp, input string nm);
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check({nm, " valid drop"}, int'(valid), 0);
    check({nm, " busy idle"}, int'(busy), 0);
    @(negedge clk);
    check({nm, " stays idle"}, int'(busy | valid), 0);
    check({nm, " data kept"}, int'(data), int'(exp));
  endtask

  initial begin
    tests = 0;
    fails = 0;
    vecs[0] = '{pat: 4'b0000, exp: 4'b0000};
    vecs[1] = '{pat: 4'b1111, exp: 4'b1111};
    vecs[2] = '{pat: 4'b0101, exp: 4'b0101};
    vecs[3] = '{pat: 4'b0001, exp: 4'b0001};
    vecs[4] = '{pat: 4'b1000, exp: 4'b1000};
    vecs[5] = '{pat: 4'b0011, exp: 4'b0011};

    rst = 1'b1; start = 1'b0; ready = 1'b0; in_i = 4'b0000;
    start0 = 1'b0; ready0 = 1'b0; in0 = 4'b0000;
    repeat (2) @(negedge clk);
    check("reset s", int'(s), 0);
    check("reset busy", int'(busy), 0);
    check("reset valid", int'(valid), 0);
    check("reset data", int'(data), 0);
    check("reset valid0", int'(valid0), 0);
    rst = 1'b0;

    // Basic scan with the full select sequence checked.
    start_scan(4'b1010, 1'b0, "scan1010");
    walk(4'b1010, 4'b1010, 0, 0, 4'b1010, 1'b1, "scan1010");
    handshake(4'b1010, "scan1010");

    // Backpressure: hold 10 cycles with ignored start pulses.
    start_scan(4'b1001, 1'b0, "hold1001");
    walk(4'b1001, 4'b1001, 0, 0, 4'b1001, 1'b0, "hold1001");
    for (int c = 0; c < 10; c++) begin
      start = (c % 3 == 1);
      in_i  = 4'(c);
      @(negedge clk);
      check($sformatf("hold valid c%0d", c), int'(valid), 1);
      check($sformatf("hold data c%0d", c), int'(data), 4'b1001);
      check($sformatf("hold busy c%0d", c), int'(busy), 0);
    end
    start = 1'b0;
    handshake(4'b1001, "hold1001");

    // ready and start together in HOLD restart with no bubble.
    start_scan(4'b1010, 1'b0, "b2b first");
    walk(4'b1010, 4'b1010, 0, 0, 4'b1010, 1'b0, "b2b first");
    start_scan(4'b0110, 1'b1, "b2b second");
    walk(4'b0110, 4'b0110, 0, 0, 4'b0110, 1'b1, "b2b second");
    handshake(4'b0110, "b2b second");

    // y changes between sample edges are ignored: sampled bits 0,1,0,1.
    start_scan(4'b1000, 1'b0, "toggle");
    walk(4'b1000, 4'b0111, 5, 7, 4'b1010, 1'b0, "toggle");
    handshake(4'b1010, "toggle");

    // Async reset mid-scan, checked before any further clock edge.
    start_scan(4'b0101, 1'b0, "midrst");
    repeat (5) @(negedge clk);
    check("midrst busy before", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("midrst s", int'(s), 0);
    check("midrst busy", int'(busy), 0);
    check("midrst valid", int'(valid), 0);
    check("midrst data", int'(data), 0);
    @(negedge clk);
    rst = 1'b0;
    start_scan(4'b1100, 1'b0, "postrst");
    walk(4'b1100, 4'b1100, 0, 0, 4'b1100, 1'b1, "postrst");
    handshake(4'b1100, "postrst");

    // Table-driven patterns.
    for (int i = 0; i < 6; i++) begin
      start_scan(vecs[i].pat, 1'b0, $sformatf("vec%0d", i));
      walk(vecs[i].pat, vecs[i].pat, 0, 0, vecs[i].exp, 1'b0, $sformatf("vec%0d", i));
      handshake(vecs[i].exp, $sformatf("vec%0d", i));
    end

    // SETTLE=0: select advances every edge, valid after edge 4.
    @(negedge clk);
    in0 = 4'b1110;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    check("s0 busy@e0", int'(busy0), 1);
    check("s0 s@e0", int'(s0), 0);
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk);
      check($sformatf("s0 s@e%0d", e), int'(s0), e);
      check($sformatf("s0 valid@e%0d", e), int'(valid0), 0);
    end
    @(negedge clk);
    check("s0 valid@e4", int'(valid0), 1);
    check("s0 data", int'(data0), 4'b1110);
    check("s0 s@e4", int'(s0), 0);
    ready0 = 1'b1;
    @(negedge clk);
    ready0 = 1'b0;
    check("s0 valid drop", int'(valid0), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
